// File: rtl/cpu_msg_arbiter_pkg.sv
// Shared inter-CPU message definitions: request/answer codes and the
// arbiter FSM state encoding.
package cpu_msg_arbiter_pkg;

  localparam int unsigned CODE_W = 8;

  // Requests raised by thread controllers
  localparam logic [CODE_W-1:0] CPU_R_FORK_THRD = 8'h01;
  localparam logic [CODE_W-1:0] CPU_R_STOP_THRD = 8'h02;
  // Answers returned by the dispatcher
  localparam logic [CODE_W-1:0] CPU_R_FORK_DONE = 8'h81;
  localparam logic [CODE_W-1:0] CPU_R_STOP_DONE = 8'h82;
  // Failure reply: unknown request, wrong answer or timeout
  localparam logic [CODE_W-1:0] CPU_R_ERR       = 8'hEE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_REPLY = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req searching upward from last+1,
// wrapping modulo N_REQ.
//   req   : pending-request vector
//   last  : index granted most recently
//   idx   : chosen index (0 when nothing is pending)
//   found : at least one request pending
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Walk from the farthest candidate down to last+1 so the nearest one wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      if (req[IDX_W'((int'(last) + i) % int'(N_REQ))]) begin
        idx   = IDX_W'((int'(last) + i) % int'(N_REQ));
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_msg_arbiter.sv
// Arbitrates fork/stop requests from N_REQ thread controllers onto a single
// dispatcher and routes the dispatcher's answer back to the requester.
//   clk, rst     : clock, synchronous active-high reset
//   req_pulse    : per-requester one-cycle request strobe
//   req_msg/addr/data : per-requester request payload (flattened lanes)
//   rsp_msg      : per-requester reply code (only the granted lane non-zero)
//   rsp_data     : shared reply data
//   disp_online  : arbiter ready
//   disp_pulse   : one-cycle issue strobe, with disp_msg/addr/data
//   done_valid/msg/data : dispatcher answer
//   overflow     : sticky per-requester dropped-request flags
module cpu_msg_arbiter
  import cpu_msg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MSG_W   = 8,
  parameter int unsigned HOLD    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_pulse,
  input  logic [N_REQ*MSG_W-1:0]  req_msg,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ*MSG_W-1:0]  rsp_msg,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    disp_online,
  output logic                    disp_pulse,
  output logic [MSG_W-1:0]        disp_msg,
  output logic [ADDR_W-1:0]       disp_addr,
  output logic [DATA_W-1:0]       disp_data,
  input  logic                    done_valid,
  input  logic [MSG_W-1:0]        done_msg,
  input  logic [DATA_W-1:0]       done_data,
  output logic [N_REQ-1:0]        overflow
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD + 1);
  localparam int unsigned TMO_W  = 8;

  localparam logic [MSG_W-1:0] M_FORK      = MSG_W'(CPU_R_FORK_THRD);
  localparam logic [MSG_W-1:0] M_STOP      = MSG_W'(CPU_R_STOP_THRD);
  localparam logic [MSG_W-1:0] M_FORK_DONE = MSG_W'(CPU_R_FORK_DONE);
  localparam logic [MSG_W-1:0] M_STOP_DONE = MSG_W'(CPU_R_STOP_DONE);
  localparam logic [MSG_W-1:0] M_ERR       = MSG_W'(CPU_R_ERR);

  // Capture slots
  logic [N_REQ-1:0]  slot_valid;
  logic [MSG_W-1:0]  slot_msg  [N_REQ];
  logic [ADDR_W-1:0] slot_addr [N_REQ];
  logic [DATA_W-1:0] slot_data [N_REQ];

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  grant, grant_nxt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              take;
  logic [MSG_W-1:0]  cur_msg, cur_msg_nxt;
  logic [MSG_W-1:0]  exp_done;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nxt;
  logic [N_REQ-1:0]  in_flight;

  logic                   disp_pulse_nxt;
  logic [MSG_W-1:0]       disp_msg_nxt;
  logic [ADDR_W-1:0]      disp_addr_nxt;
  logic [DATA_W-1:0]      disp_data_nxt;
  logic [N_REQ*MSG_W-1:0] rsp_msg_nxt;
  logic [DATA_W-1:0]      rsp_data_nxt;

  // Place a reply code on one lane, zero elsewhere.
  function automatic logic [N_REQ*MSG_W-1:0] lane_put(input logic [IDX_W-1:0] lane,
                                                      input logic [MSG_W-1:0] code);
    lane_put = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (lane == IDX_W'(i)) lane_put[i*MSG_W +: MSG_W] = code;
    end
  endfunction

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (slot_valid),
    .last  (grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A requester stays in flight from grant until the arbiter is idle again.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      in_flight[i] = (state != S_IDLE) && (grant == IDX_W'(i));
    end
  end

  // Slot capture, grant clear and overflow tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      overflow   <= '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        slot_msg[i]  <= '0;
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (take && (pick_idx == IDX_W'(i))) slot_valid[i] <= 1'b0;
        if (req_pulse[i]) begin
          if (slot_valid[i] || in_flight[i]) begin
            overflow[i] <= 1'b1;
          end else begin
            slot_valid[i] <= 1'b1;
            slot_msg[i]   <= req_msg[i*MSG_W +: MSG_W];
            slot_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
            slot_data[i]  <= req_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Answer code that a correct dispatcher returns for the granted request
  assign exp_done = (cur_msg == M_FORK) ? M_FORK_DONE : M_STOP_DONE;

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    take           = 1'b0;
    cur_msg_nxt    = cur_msg;
    hold_cnt_nxt   = hold_cnt;
    tmo_cnt_nxt    = tmo_cnt;
    disp_pulse_nxt = 1'b0;
    disp_msg_nxt   = '0;
    disp_addr_nxt  = '0;
    disp_data_nxt  = '0;
    rsp_msg_nxt    = '0;
    rsp_data_nxt   = '0;

    case (state)
      S_IDLE: begin
        if (pick_found) begin
          take         = 1'b1;
          grant_nxt    = pick_idx;
          cur_msg_nxt  = slot_msg[pick_idx];
          hold_cnt_nxt = '0;
          tmo_cnt_nxt  = '0;
          if ((slot_msg[pick_idx] == M_FORK) || (slot_msg[pick_idx] == M_STOP)) begin
            disp_pulse_nxt = 1'b1;
            disp_msg_nxt   = slot_msg[pick_idx];
            disp_addr_nxt  = slot_addr[pick_idx];
            disp_data_nxt  = slot_data[pick_idx];
            state_nxt      = S_ISSUE;
          end else begin
            // Unknown request never reaches the dispatcher
            rsp_msg_nxt = lane_put(pick_idx, M_ERR);
            state_nxt   = S_REPLY;
          end
        end
      end

      S_ISSUE: begin
        tmo_cnt_nxt = '0;
        state_nxt   = S_WAIT;
      end

      S_WAIT: begin
        if (done_valid) begin
          rsp_msg_nxt  = lane_put(grant, (done_msg == exp_done) ? done_msg : M_ERR);
          rsp_data_nxt = done_data;
          tmo_cnt_nxt  = '0;
          state_nxt    = S_REPLY;
        end else if (tmo_cnt >= TMO_W'(TIMEOUT - 1)) begin
          rsp_msg_nxt = lane_put(grant, M_ERR);
          tmo_cnt_nxt = '0;
          state_nxt   = S_REPLY;
        end else begin
          tmo_cnt_nxt = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TMO_W'(1);
        end
      end

      S_REPLY: begin
        if (hold_cnt == HOLD_W'(HOLD - 1)) begin
          hold_cnt_nxt = '0;
          state_nxt    = S_IDLE;
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          rsp_msg_nxt  = rsp_msg;
          rsp_data_nxt = rsp_data;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= IDX_W'(N_REQ - 1);
      cur_msg     <= '0;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      disp_online <= 1'b0;
      disp_pulse  <= 1'b0;
      disp_msg    <= '0;
      disp_addr   <= '0;
      disp_data   <= '0;
      rsp_msg     <= '0;
      rsp_data    <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      cur_msg     <= cur_msg_nxt;
      hold_cnt    <= hold_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      disp_online <= 1'b1;
      disp_pulse  <= disp_pulse_nxt;
      disp_msg    <= disp_msg_nxt;
      disp_addr   <= disp_addr_nxt;
      disp_data   <= disp_data_nxt;
      rsp_msg     <= rsp_msg_nxt;
      rsp_data    <= rsp_data_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_msg_arbiter.sv
// Self-checking bench for cpu_msg_arbiter: directed scenarios followed by
// random request bursts checked against a transaction-level model.
module tb_cpu_msg_arbiter;
  import cpu_msg_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int HOLD = 2;
  localparam int TMO  = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_pulse;
  logic [31:0]  req_msg;
  logic [127:0] req_addr;
  logic [127:0] req_data;
  logic [31:0]  rsp_msg;
  logic [31:0]  rsp_data;
  logic         disp_online;
  logic         disp_pulse;
  logic [7:0]   disp_msg;
  logic [31:0]  disp_addr;
  logic [31:0]  disp_data;
  logic         done_valid;
  logic [7:0]   done_msg;
  logic [31:0]  done_data;
  logic [3:0]   overflow;

  int errors = 0;
  int checks = 0;
  int model_last;

  logic [7:0]  b_msg  [4];
  logic [31:0] b_addr [4];
  logic [31:0] b_data [4];

  cpu_msg_arbiter #(
    .N_REQ(4), .ADDR_W(32), .DATA_W(32), .MSG_W(8), .HOLD(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_pulse(req_pulse), .req_msg(req_msg), .req_addr(req_addr), .req_data(req_data),
    .rsp_msg(rsp_msg), .rsp_data(rsp_data), .disp_online(disp_online),
    .disp_pulse(disp_pulse), .disp_msg(disp_msg), .disp_addr(disp_addr), .disp_data(disp_data),
    .done_valid(done_valid), .done_msg(done_msg), .done_data(done_data),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int lane, input logic [7:0] m, input logic [31:0] a,
                         input logic [31:0] d);
    req_pulse[lane]          = 1'b1;
    req_msg[lane*8 +: 8]     = m;
    req_addr[lane*32 +: 32]  = a;
    req_data[lane*32 +: 32]  = d;
  endtask

  // Round-robin rule: first pending index after last, wrapping.
  function automatic int rr_next(input logic [3:0] pend, input int last);
    for (int i = 1; i <= N; i++) begin
      if (pend[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] match_code(input logic [7:0] m);
    return (m == CPU_R_FORK_THRD) ? CPU_R_FORK_DONE : CPU_R_STOP_DONE;
  endfunction

  // Follow one granted request through issue, answer and reply.
  // timeout=1: never answer. poke=1: stray answer during the issue cycle.
  task automatic serve(input int lane, input logic [7:0] m, input logic [31:0] a,
                       input logic [31:0] d, input bit timeout, input logic [7:0] ans_msg,
                       input logic [31:0] ans_data, input int delay, input bit poke);
    logic [7:0]  code;
    logic [31:0] rdata;
    logic [31:0] lane_v;
    int n;
    int seen;
    if (m == CPU_R_FORK_THRD || m == CPU_R_STOP_THRD) begin
      n = 0;
      while (disp_pulse !== 1'b1 && n < 20) begin tick(); n++; end
      chk("disp_pulse_seen", disp_pulse, 1'b1);
      chk("disp_msg", disp_msg, m);
      chk("disp_addr", disp_addr, a);
      chk("disp_data", disp_data, d);
      if (poke) begin
        done_valid = 1'b1; done_msg = match_code(m); done_data = 32'hDEAD_BEEF;
      end
      tick();
      done_valid = 1'b0; done_msg = '0; done_data = '0;
      chk("disp_pulse_one_cycle", disp_pulse, 1'b0);
      chk("disp_fields_zero", {disp_msg, disp_addr, disp_data}, 72'h0);
      if (!timeout) begin
        repeat (delay) tick();
        chk("rsp_quiet_in_wait", rsp_msg, 32'h0);
        done_valid = 1'b1; done_msg = ans_msg; done_data = ans_data;
        tick();
        done_valid = 1'b0; done_msg = '0; done_data = '0;
        code  = (ans_msg == match_code(m)) ? ans_msg : CPU_R_ERR;
        rdata = ans_data;
      end else begin
        n = 0;
        while (rsp_msg == 32'h0 && n < 300) begin tick(); n++; end
        chk("timeout_wait_cycles", n, TMO);
        code  = CPU_R_ERR;
        rdata = '0;
      end
    end else begin
      n = 0; seen = 0;
      while (rsp_msg == 32'h0 && n < 20) begin
        tick(); n++;
        if (disp_pulse === 1'b1) seen++;
      end
      chk("garbage_no_disp", seen, 0);
      code  = CPU_R_ERR;
      rdata = '0;
    end
    lane_v = '0;
    lane_v[lane*8 +: 8] = code;
    for (int h = 0; h < HOLD; h++) begin
      chk("rsp_msg", rsp_msg, lane_v);
      chk("rsp_data", rsp_data, rdata);
      if (h < HOLD - 1) tick();
    end
    tick();
    chk("rsp_msg_after_hold", rsp_msg, 32'h0);
    chk("rsp_data_after_hold", rsp_data, 32'h0);
    model_last = lane;
  endtask

  // Pulse every requester in mask together, then serve them in model order.
  task automatic run_burst(input logic [3:0] mask, input bit rnd);
    logic [3:0] pend;
    logic [7:0] ans;
    int j;
    int r;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) set_req(i, b_msg[i], b_addr[i], b_data[i]);
    end
    tick();
    req_pulse = '0;
    pend = mask;
    while (pend != 4'h0) begin
      j = rr_next(pend, model_last);
      ans = match_code(b_msg[j]);
      if (rnd) begin
        r = $urandom_range(0, 3);
        if (r == 1) ans = (ans == CPU_R_FORK_DONE) ? CPU_R_STOP_DONE : CPU_R_FORK_DONE;
        else if (r == 2) ans = 8'($urandom_range(0, 255));
        serve(j, b_msg[j], b_addr[j], b_data[j], 1'b0, ans, $urandom,
              $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end else begin
        serve(j, b_msg[j], b_addr[j], b_data[j], 1'b0, ans, 32'hA000 + 32'(j), 1, 1'b0);
      end
      pend[j] = 1'b0;
    end
  endtask

  initial begin
    int act;
    logic [7:0] g;
    rst = 1'b1;
    req_pulse = '0; req_msg = '0; req_addr = '0; req_data = '0;
    done_valid = 1'b0; done_msg = '0; done_data = '0;
    model_last = N - 1;

    // Reset state
    repeat (3) tick();
    chk("rst_online", disp_online, 1'b0);
    chk("rst_disp", {disp_pulse, disp_msg, disp_addr, disp_data}, 73'h0);
    chk("rst_rsp", {rsp_msg, rsp_data}, 64'h0);
    chk("rst_overflow", overflow, 4'h0);
    rst = 1'b0;
    tick();
    chk("online_after_rst", disp_online, 1'b1);

    // Answer while idle is ignored
    done_valid = 1'b1; done_msg = CPU_R_FORK_DONE; done_data = 32'h77;
    tick();
    done_valid = 1'b0; done_msg = '0; done_data = '0;
    act = 0;
    repeat (3) begin
      if (rsp_msg != 0 || rsp_data != 0 || disp_pulse) act++;
      tick();
    end
    chk("idle_done_ignored", act, 0);

    // Single fork with exact latency
    set_req(0, CPU_R_FORK_THRD, 32'h100, 32'h200);
    tick();
    req_pulse = '0;
    chk("fork_cycle1_no_disp", disp_pulse, 1'b0);
    tick();
    chk("fork_cycle2_disp", disp_pulse, 1'b1);
    serve(0, CPU_R_FORK_THRD, 32'h100, 32'h200, 1'b0, CPU_R_FORK_DONE, 32'h55, 0, 1'b0);

    // Fresh reset so all four pulse right after reset
    rst = 1'b1; tick(); rst = 1'b0; model_last = N - 1; tick();
    for (int i = 0; i < N; i++) begin
      b_msg[i]  = (i % 2 == 0) ? CPU_R_FORK_THRD : CPU_R_STOP_THRD;
      b_addr[i] = 32'h1000 + 32'(i);
      b_data[i] = 32'h2000 + 32'(i);
    end
    run_burst(4'b1111, 1'b0);
    run_burst(4'b0100, 1'b0);
    run_burst(4'b1010, 1'b0);

    // Timeout
    set_req(1, CPU_R_STOP_THRD, 32'h500, 32'h600);
    tick();
    req_pulse = '0;
    serve(1, CPU_R_STOP_THRD, 32'h500, 32'h600, 1'b1, 8'h0, 32'h0, 0, 1'b0);

    // Mismatched answer (with a stray answer in the issue cycle), then garbage code
    set_req(0, CPU_R_FORK_THRD, 32'h300, 32'h400);
    tick();
    req_pulse = '0;
    serve(0, CPU_R_FORK_THRD, 32'h300, 32'h400, 1'b0, CPU_R_STOP_DONE, 32'h66, 2, 1'b1);
    set_req(2, 8'h7F, 32'h700, 32'h800);
    tick();
    req_pulse = '0;
    serve(2, 8'h7F, 32'h700, 32'h800, 1'b0, 8'h0, 32'h0, 0, 1'b0);

    // Overflow: req3 pulses twice while in flight
    set_req(3, CPU_R_FORK_THRD, 32'h900, 32'hA00);
    tick();
    req_pulse = '0;
    tick();
    chk("ovf_disp", disp_pulse, 1'b1);
    tick();
    set_req(3, CPU_R_STOP_THRD, 32'h901, 32'hA01);
    tick();
    req_pulse = '0;
    chk("ovf_first_drop", overflow, 4'b1000);
    set_req(3, CPU_R_FORK_THRD, 32'h902, 32'hA02);
    tick();
    req_pulse = '0;
    done_valid = 1'b1; done_msg = CPU_R_FORK_DONE; done_data = 32'h33;
    tick();
    done_valid = 1'b0; done_msg = '0; done_data = '0;
    chk("ovf_rsp_msg", rsp_msg, 32'h8100_0000);
    chk("ovf_rsp_data", rsp_data, 32'h33);
    model_last = 3;
    act = 0;
    repeat (12) begin
      tick();
      if (disp_pulse === 1'b1) act++;
    end
    chk("ovf_single_disp", act, 0);
    chk("ovf_sticky", overflow, 4'b1000);

    // Reset during WAIT, late answer ignored
    set_req(0, CPU_R_FORK_THRD, 32'hB00, 32'hC00);
    tick();
    req_pulse = '0;
    tick();
    chk("rstwait_disp", disp_pulse, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rstwait_online", disp_online, 1'b0);
    chk("rstwait_outputs", {rsp_msg, rsp_data, disp_pulse, disp_msg, disp_addr, disp_data}, 137'h0);
    chk("rstwait_overflow", overflow, 4'h0);
    rst = 1'b0;
    model_last = N - 1;
    done_valid = 1'b1; done_msg = CPU_R_FORK_DONE; done_data = 32'h99;
    tick();
    done_valid = 1'b0; done_msg = '0; done_data = '0;
    chk("rstwait_online_back", disp_online, 1'b1);
    act = 0;
    repeat (6) begin
      if (rsp_msg != 0 || rsp_data != 0 || disp_pulse) act++;
      tick();
    end
    chk("rstwait_quiet", act, 0);
    set_req(1, CPU_R_STOP_THRD, 32'hD00, 32'hE00);
    tick();
    req_pulse = '0;
    chk("rstwait_c1_no_disp", disp_pulse, 1'b0);
    tick();
    chk("rstwait_c2_disp", disp_pulse, 1'b1);
    serve(1, CPU_R_STOP_THRD, 32'hD00, 32'hE00, 1'b0, CPU_R_STOP_DONE, 32'h44, 1, 1'b0);

    // Random bursts against the model
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0, 1: b_msg[i] = CPU_R_FORK_THRD;
          2:    b_msg[i] = CPU_R_STOP_THRD;
          default: begin
            g = 8'($urandom_range(0, 255));
            while (g == CPU_R_FORK_THRD || g == CPU_R_STOP_THRD) g = 8'($urandom_range(0, 255));
            b_msg[i] = g;
          end
        endcase
        b_addr[i] = $urandom;
        b_data[i] = $urandom;
      end
      run_burst(4'($urandom_range(1, 15)), 1'b1);
    end
    chk("rand_no_overflow", overflow, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_msg_arbiter.md
CPU_MSG_ARBITER -- requirements
Module: cpu_msg_arbiter

Interface
REQ-001 Parameters (name, default, meaning): N_REQ, 4, number of thread-controller requesters.
REQ-002 ADDR_W, 32, address width; DATA_W, 32, data width; MSG_W, 8, inter-CPU message width.
REQ-003 HOLD, 2, reply hold length in cycles; TIMEOUT, 255, maximum cycles to wait for a dispatcher answer.
REQ-004 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 req_pulse  in  N_REQ  per-requester one-cycle request strobe.
REQ-006 req_msg  in  N_REQ*MSG_W  per-requester request code, CPU_R_FORK_THRD or CPU_R_STOP_THRD.
REQ-007 req_addr  in  N_REQ*ADDR_W  per-requester address; req_data  in  N_REQ*DATA_W  per-requester data.
REQ-008 rsp_msg  out  N_REQ*MSG_W  per-requester reply code; rsp_data  out  DATA_W  shared reply data.
REQ-009 disp_online  out  1  arbiter ready, routed to every requester.
REQ-010 disp_pulse  out  1  one-cycle issue strobe to the dispatcher; disp_msg/disp_addr/disp_data  out  MSG_W/ADDR_W/DATA_W  issued request.
REQ-011 done_valid  in  1  dispatcher answer strobe; done_msg  in  MSG_W  answer code; done_data  in  DATA_W  answer data.
REQ-012 overflow  out  N_REQ  sticky per-requester dropped-request flag.

Function
REQ-013 Per-requester capture slot (valid, msg, addr, data) SHALL load on req_pulse when the slot is empty and that requester is not in flight.
REQ-014 A req_pulse to a full slot or an in-flight requester SHALL be dropped and SHALL set that requester's overflow bit.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, REPLY.
REQ-016 IDLE: if any slot is valid, grant round-robin starting at last_grant+1 modulo N_REQ, clear that slot, go to ISSUE.
REQ-017 IDLE with an unknown request code: skip the dispatcher, go to REPLY with code CPU_R_ERR and data 0.
REQ-018 ISSUE: assert disp_pulse for exactly one cycle with the granted msg/addr/data, go to WAIT; disp_msg/addr/data SHALL be 0 whenever disp_pulse is 0.
REQ-019 WAIT: on done_valid, latch done_data and go to REPLY; code SHALL be done_msg if it matches the request (FORK_THRD->FORK_DONE, STOP_THRD->STOP_DONE), otherwise CPU_R_ERR.
REQ-020 WAIT: after TIMEOUT cycles without done_valid, go to REPLY with CPU_R_ERR and data 0; the timeout counter SHALL be 8 bits wide and saturate.
REQ-021 REPLY: drive the code on the granted lane of rsp_msg and the data on rsp_data for exactly HOLD cycles, then go to IDLE; all other lanes SHALL be 0.
REQ-022 rsp_data SHALL be 0 outside REPLY.
REQ-023 done_valid outside WAIT SHALL be ignored.
REQ-024 Latency: req_pulse at cycle 0 on an idle arbiter gives disp_pulse in cycle 2; done_valid in cycle k gives the reply in cycles k+1 .. k+HOLD.
REQ-025 Simultaneous pulses SHALL all be captured; service order SHALL follow REQ-016.
REQ-026 disp_online SHALL be 1 except during the cycle rst is sampled high.

Reset
REQ-027 On rst: FSM goes to IDLE; all slots are cleared; last_grant = N_REQ-1 (requester 0 served first); overflow, rsp_msg, rsp_data, disp_* are all 0; the timeout counter is 0.
REQ-028 rst asserted mid-transaction SHALL abandon it without a reply; a dispatcher answer arriving later SHALL be ignored.

Structure
REQ-029 The message codes CPU_R_FORK_THRD, CPU_R_STOP_THRD, CPU_R_FORK_DONE, CPU_R_STOP_DONE and CPU_R_ERR, and the FSM state encoding, SHALL live in the shared inter-CPU message package.
REQ-030 The round-robin grant SHALL be one sub-module, rr_pick (N_REQ-bit request vector plus last_grant in, index and found out, combinational).

Verification
REQ-031 Single fork: req0 pulse with FORK_THRD, addr 0x100, data 0x200 -> disp_pulse in cycle 2 with those values; done_valid with FORK_DONE, data 0x55 -> rsp_msg lane 0 = FORK_DONE and rsp_data = 0x55 for 2 cycles.
REQ-032 All four requesters pulse in the same cycle after reset -> issue order 0,1,2,3; next lone req2 pulse after last_grant=3 -> served next, order proven rotating.
REQ-033 Timeout: STOP_THRD from req1 with no done_valid -> after 255 WAIT cycles rsp_msg lane 1 = CPU_R_ERR, rsp_data = 0.
REQ-034 Mismatch and garbage: FORK answered with STOP_DONE -> CPU_R_ERR; request code 0x7F -> CPU_R_ERR with no disp_pulse.
REQ-035 Overflow: req3 pulses twice while its request is in flight -> overflow[3] = 1 sticky, exactly one disp_pulse for req3.
REQ-036 Reset during WAIT, then done_valid -> no rsp_msg activity; FSM in IDLE; all outputs 0.
